// File: rtl/spi_regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_regfile_pkg
//  Purpose  : Shared types and constants for the SPI register-file slave.
//             Frame FSM state encoding, R/W command bit values and the
//             frame-length helper.
//  Revision : 1.0  initial release
// ============================================================================
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total frame length: one R/W bit, the address field, then the data.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage : spi_regfile_pkg
`default_nettype wire

// File: rtl/spi_regfile_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_regfile_slave_if
//  Purpose  : SPI pin bundle between an SPI master and the register-file
//             slave.
//  Signals  : spi_sclk, spi_cs_n, spi_mosi  (master -> slave)
//             spi_miso, spi_miso_oe         (slave  -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface spi_regfile_slave_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface : spi_regfile_slave_if
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//             third flop used for edge detection.
//  Ports    : clk, rst_n   system clock, asynchronous active-low reset
//             i_async      asynchronous input
//             o_level      synchronized level
//             o_rise       one-cycle pulse on a synchronized 0->1 transition
//             o_fall       one-cycle pulse on a synchronized 1->0 transition
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // [0],[1] synchronizer stages; [2] previous synchronized value.
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], i_async};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_level = sync_q[1];
    assign o_rise  =  sync_q[1] & ~sync_q[2];
    assign o_fall  = ~sync_q[1] &  sync_q[2];

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_regfile_slave
//  Purpose  : SPI mode-0 register-file slave, oversampled in the clk domain.
//             Frame = R/W bit, ADDR_W address bits, DATA_W data bits, MSB
//             first. Writes commit on chip-select release; reads shift the
//             addressed register out on MISO. Malformed frames are discarded
//             and flagged.
//  Ports    : clk, rst_n     system clock, asynchronous active-low reset
//             spi            SPI pins (slave modport)
//             regs_o         flattened registers, reg i at [i*DATA_W +: DATA_W]
//             wr_strobe      one-cycle pulse on a committed write
//             wr_addr        address of the last committed write
//             frame_err      one-cycle pulse on a discarded malformed frame
//  Revision : 1.0  initial release
// ============================================================================
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  wire                          clk,
    input  wire                          rst_n,
    spi_regfile_slave_if.slave           spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    wire w_unused_ok = &{1'b0, w_sclk_lvl, w_mosi_rise_unused, w_mosi_fall_unused};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                       state_q,     state_d;
    logic [CNT_W-1:0]             bit_cnt_q,   bit_cnt_d;
    logic [SHIFT_W-1:0]           shift_q,     shift_d;
    logic                         rw_q,        rw_d;
    logic [ADDR_W-1:0]            addr_q,      addr_d;
    logic [DATA_W-1:0]            out_q,       out_d;
    logic                         miso_q,      miso_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q,      regs_d;
    logic                         wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]            wr_addr_q,   wr_addr_d;
    logic                         frame_err_q, frame_err_d;
    // After reset the synchronizers start at idle levels, so a cs_n that is
    // already low would look like a fresh fall. armed_q is only set once
    // the pipeline has flushed and cs_n has been seen high.
    logic [1:0]                   arm_cnt_q,   arm_cnt_d;
    logic                         armed_q,     armed_d;

    // Command word as it stands when the last address bit is sampled.
    logic [ADDR_W:0]   w_cmd;
    logic [DATA_W-1:0] w_rd_word;

    assign w_cmd = {shift_q[ADDR_W-1:0], w_mosi};

    // Addresses beyond the implemented range read back as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_rd_word = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        out_d       = out_q;
        miso_d      = miso_q;
        regs_d      = regs_q;
        wr_addr_d   = wr_addr_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        arm_cnt_d   = (arm_cnt_q == 2'd3) ? arm_cnt_q : arm_cnt_q + 2'd1;
        armed_d     = armed_q | ((arm_cnt_q == 2'd3) & w_cs_lvl);

        if ((state_q != IDLE) && w_cs_rise) begin
            state_d = IDLE;
            if (state_q == DONE) begin
                if (rw_q == RW_WRITE) begin
                    // Out-of-range addresses match no register: dropped.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) begin
                            regs_d[i*DATA_W +: DATA_W] = shift_q[DATA_W-1:0];
                            wr_strobe_d                = 1'b1;
                            wr_addr_d                  = addr_q;
                        end
                    end
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_cs_fall && armed_q) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        shift_d   = {shift_q[SHIFT_W-2:0], w_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                            state_d = DATA;
                            rw_d    = w_cmd[ADDR_W];
                            addr_d  = w_cmd[ADDR_W-1:0];
                            out_d   = (w_cmd[ADDR_W] == RW_READ) ? w_rd_word : '0;
                            miso_d  = 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_sclk_rise) begin
                        shift_d   = {shift_q[SHIFT_W-2:0], w_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = DONE;
                        end
                    end
                    if (w_sclk_fall && (rw_q == RW_READ)) begin
                        miso_d = out_q[DATA_W-1];
                        out_d  = {out_q[DATA_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    if (w_sclk_rise) begin
                        state_d = ERR;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            out_q       <= '0;
            miso_q      <= 1'b0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            arm_cnt_q   <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            miso_q      <= miso_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            arm_cnt_q   <= arm_cnt_d;
            armed_q     <= armed_d;
        end
    end

    // MISO is only driven during the data/done phase of a read frame.
    logic w_oe;
    assign w_oe = ~w_cs_lvl & (rw_q == RW_READ) & ((state_q == DATA) || (state_q == DONE));

    assign spi.spi_miso_oe = w_oe;
    assign spi.spi_miso    = w_oe & miso_q;
    assign regs_o          = regs_q;
    assign wr_strobe       = wr_strobe_q;
    assign wr_addr         = wr_addr_q;
    assign frame_err       = frame_err_q;

endmodule : spi_regfile_slave
`default_nettype wire

// File: tb/tb_spi_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_regfile_slave
//  Purpose  : Directed self-checking bench for spi_regfile_slave with the
//             default parameters (5 registers, 8-bit data, 7-bit address).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_regfile_slave;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_regfile_slave_if sif ();

    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    spi_regfile_slave #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (sif),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    int half_ns = 40;

    // Pulse monitors: each clk cycle a pulse is high counts once.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_addr = wr_addr;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clock out bits [nbits-1:0] of word, MSB first, with cs_n already low.
    // MISO/OE are sampled just before each rising sclk edge.
    task automatic spi_bits(input logic [31:0] word, input int nbits,
                            output logic [7:0] rx, output int oe_cmd, output int oe_dat);
        rx = '0; oe_cmd = 0; oe_dat = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sif.spi_mosi = word[i];
            #(half_ns);
            if ((nbits - 1 - i) <= ADDR_W) begin
                oe_cmd += int'(sif.spi_miso_oe);
            end else begin
                oe_dat += int'(sif.spi_miso_oe);
                rx = {rx[6:0], sif.spi_miso};
            end
            sif.spi_sclk = 1'b1;
            #(half_ns);
            sif.spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits, input int gap_ns,
                             output logic [7:0] rx, output int oe_cmd, output int oe_dat);
        sif.spi_cs_n = 1'b0;
        #(half_ns);
        spi_bits(word, nbits, rx, oe_cmd, oe_dat);
        #(half_ns);
        sif.spi_cs_n = 1'b1;
        sif.spi_mosi = 1'b0;
        #(gap_ns);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int oc, od, s0, e0;

        sif.spi_sclk = 1'b0;
        sif.spi_cs_n = 1'b1;
        sif.spi_mosi = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_regs",   64'(regs_o), 64'h0);
        chk("rst_oe",     64'(sif.spi_miso_oe), 64'h0);
        chk("rst_miso",   64'(sif.spi_miso), 64'h0);
        chk("rst_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_err",    64'(frame_err), 64'h0);
        chk("rst_waddr",  64'(wr_addr), 64'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 1: write reg2 = A5
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(32'h82A5, 16, 2*half_ns, rx, oc, od);
        settle();
        chk("t1_regs",   64'(regs_o), 64'h00_00_A5_00_00);
        chk("t1_strobe", 64'(strobe_cnt - s0), 64'd1);
        chk("t1_waddr",  64'(last_addr), 64'd2);
        chk("t1_err",    64'(err_cnt - e0), 64'd0);

        // 2: read reg2, then out-of-range addr 9
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(32'h0200, 16, 2*half_ns, rx, oc, od);
        settle();
        chk("t2_rd_data", 64'(rx), 64'hA5);
        chk("t2_oe_cmd",  64'(oc), 64'd0);
        chk("t2_oe_data", 64'(od), 64'd8);
        chk("t2_oe_idle", 64'(sif.spi_miso_oe), 64'h0);
        chk("t2_regs",    64'(regs_o), 64'h00_00_A5_00_00);
        spi_frame(32'h0900, 16, 2*half_ns, rx, oc, od);
        settle();
        chk("t2_rd_oor",  64'(rx), 64'h00);
        chk("t2_rd_side", 64'({strobe_cnt - s0, err_cnt - e0}), 64'h0);

        // 3: write to addr 7 (>= NUM_REGS) is silently dropped
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(32'h87FF, 16, 2*half_ns, rx, oc, od);
        settle();
        chk("t3_regs",   64'(regs_o), 64'h00_00_A5_00_00);
        chk("t3_strobe", 64'(strobe_cnt - s0), 64'd0);
        chk("t3_err",    64'(err_cnt - e0), 64'd0);
        chk("t3_waddr",  64'(wr_addr), 64'd2);

        // 4: short (11-bit) and long (17-bit) frames
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(32'h815A >> 5, 11, 2*half_ns, rx, oc, od);
        settle();
        chk("t4_short_err", 64'(err_cnt - e0), 64'd1);
        chk("t4_short_reg", 64'(regs_o), 64'h00_00_A5_00_00);
        e0 = err_cnt;
        spi_frame({15'd0, 16'h8133, 1'b1}, 17, 2*half_ns, rx, oc, od);
        settle();
        chk("t4_long_err",  64'(err_cnt - e0), 64'd1);
        chk("t4_long_reg",  64'(regs_o), 64'h00_00_A5_00_00);
        chk("t4_strobe",    64'(strobe_cnt - s0), 64'd0);

        // 5: reset mid-frame, then release with cs_n still low
        s0 = strobe_cnt; e0 = err_cnt;
        sif.spi_cs_n = 1'b0;
        #(half_ns);
        spi_bits(32'h803C >> 6, 10, rx, oc, od);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_rst_regs", 64'(regs_o), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_bits(32'h8055, 16, rx, oc, od);
        #(half_ns);
        sif.spi_cs_n = 1'b1;
        #(2*half_ns);
        settle();
        chk("t5_ignored_regs", 64'(regs_o), 64'h0);
        chk("t5_ignored_side", 64'({strobe_cnt - s0, err_cnt - e0}), 64'h0);
        spi_frame(32'h8042, 16, 2*half_ns, rx, oc, od);
        settle();
        chk("t5_fresh_regs",   64'(regs_o), 64'h00_00_00_00_42);
        chk("t5_fresh_strobe", 64'(strobe_cnt - s0), 64'd1);

        // 6: back-to-back writes with 3-clk cs_n high time
        s0 = strobe_cnt; e0 = err_cnt;
        spi_frame(32'h8011, 16, 30, rx, oc, od);
        spi_frame(32'h8422, 16, 30, rx, oc, od);
        settle();
        chk("t6_b2b_regs",   64'(regs_o), 64'h22_00_00_00_11);
        chk("t6_b2b_strobe", 64'(strobe_cnt - s0), 64'd2);
        chk("t6_b2b_waddr",  64'(last_addr), 64'd4);

        // 6b: sclk at clk/6 with an arbitrary phase offset
        s0 = strobe_cnt;
        half_ns = 30;
        #($urandom_range(1, 9));
        spi_frame(32'h81C3, 16, 30, rx, oc, od);
        #($urandom_range(1, 9));
        spi_frame(32'h833C, 16, 30, rx, oc, od);
        #($urandom_range(1, 9));
        spi_frame(32'h8096, 16, 30, rx, oc, od);
        @(negedge clk);
        settle();
        chk("t6_fast_regs",   64'(regs_o), 64'h22_3C_00_C3_96);
        chk("t6_fast_strobe", 64'(strobe_cnt - s0), 64'd3);
        chk("t6_fast_err",    64'(err_cnt - e0), 64'd0);
        chk("t6_fast_waddr",  64'(last_addr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_regfile_slave
`default_nettype wire

// File: doc/spi_regfile_slave.md
Name: spi_regfile_slave

Overview:
Parametrised SPI-mode-0 register-file slave. It replaces the fixed write-only SPI front end that feeds the PWM peripheral's enable and duty registers. All SPI pins are oversampled into the system clock domain. The block adds read-back on MISO, a configurable register count and width, a write strobe, and framing-error detection. Its flattened register outputs drive the PWM peripheral and any later peripherals.

Parameters:
NUM_REGS, 5, number of implemented registers (1..128)
DATA_W, 8, register width in bits; also the data-phase length of a frame
ADDR_W, 7, address field width; command byte = 1 R/W bit + ADDR_W bits
RESET_VAL, 0, reset value applied to every register

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spi_sclk  input  1  SPI clock from master, asynchronous to clk
spi_cs_n  input  1  SPI chip select, active low, asynchronous
spi_mosi  input  1  SPI data from master
spi_miso  output  1  SPI read data to master
spi_miso_oe  output  1  MISO output enable, 1 = drive
regs_o  output  NUM_REGS*DATA_W  flattened register contents; reg i at [i*DATA_W +: DATA_W]
wr_strobe  output  1  one-cycle pulse when a write commits
wr_addr  output  ADDR_W  address of the last committed write
frame_err  output  1  one-cycle pulse when a malformed frame is discarded

Behaviour:
- Reset (rst_n low, asynchronous): every register = RESET_VAL; spi_miso, spi_miso_oe, wr_strobe, frame_err, wr_addr = 0; state = IDLE; synchronizers cleared to idle levels (sclk = 0, cs_n = 1).
- Synchronisation: sclk, cs_n and mosi each pass through a 2-flop synchronizer. Rise and fall events are detected on the third flop. f_sclk <= f_clk/6 is required.
- Frame format, MSB first, 1+ADDR_W+DATA_W bits:
  - bit [MSB] = R/W (1 = write, 0 = read)
  - next ADDR_W bits = address
  - last DATA_W bits = data
- Sampling: MOSI is sampled on the sclk rise event. For reads, MISO changes on the sclk fall event.
- States: IDLE, CMD, DATA, DONE, ERR.
  - IDLE -> CMD on cs_n fall event. Bit counter and shift register are cleared.
  - CMD: shift in R/W plus address. After the last address bit, go to DATA and latch the command.
    - Read: load the output shifter from the addressed register, or 0 if addr >= NUM_REGS.
  - DATA: shift in DATA_W bits.
    - Read: on each sclk fall, present the next bit, MSB first. The first data bit is driven on the fall following the last address rise.
    - After the DATA_W-th rise, go to DONE.
  - DONE: any further sclk rise -> ERR (over-length frame).
  - Any state other than IDLE: a cs_n rise event ends the frame.
    - From DONE with a write: commit. Register[addr] <= data, wr_addr <= addr, wr_strobe = 1 for one cycle, all on the cycle after the cs_n rise event.
    - From DONE with a read: no side effect.
    - From CMD, DATA or ERR: no commit; frame_err = 1 for one cycle.
    - In all cases return to IDLE.
- Writes to addr >= NUM_REGS are dropped silently: no wr_strobe and no frame_err.
- spi_miso_oe = 1 only while cs_n is (synchronized) low and the latched command is a read in DATA or DONE. Otherwise spi_miso_oe = 0 and spi_miso = 0.
- regs_o changes only on commit and is glitch-free, being driven directly from the flops.
- Reset mid-frame: the frame is abandoned and nothing commits. After reset deasserts with cs_n already low, the slave waits for a cs_n high->low transition before accepting a new frame.

Decomposition:
- Package spi_regfile_pkg:
  - state enum {IDLE, CMD, DATA, DONE, ERR}
  - RW_WRITE = 1'b1, RW_READ = 1'b0
  - FRAME_W function of ADDR_W and DATA_W
- Sub-module spi_sync_edge: a 2-flop synchronizer plus edge-detect flop with rise/fall pulse outputs. It takes clk and rst_n, has a parameterised reset level, and is instantiated once each for sclk, cs_n and mosi (mosi uses the level output only).

Test Plan:
1. Reset with defaults -> regs_o = 0, spi_miso_oe = 0, no strobes. Then write frame 0x8_2A5 (W, addr 2, data 0xA5) -> regs_o[23:16] = 0xA5, wr_strobe pulses once, wr_addr = 2.
2. After test 1, read frame addr 2 (cmd 0x02) -> master samples 0xA5 on MISO during the data phase, spi_miso_oe = 1 only in data phase, regs unchanged. Read addr 9 -> MISO returns 0x00.
3. Write addr 7 (>= NUM_REGS) with data 0xFF -> regs_o unchanged, no wr_strobe, no frame_err.
4. Short frame: cs_n rises after 11 bits of a write to addr 1 -> frame_err pulses, reg1 unchanged. Long frame: 17 clocks -> frame_err pulses, no commit.
5. Assert rst_n low mid-DATA of a write to addr 0 -> reg0 = RESET_VAL. Release with cs_n still low and keep clocking -> ignored until cs_n toggles high then low, after which a fresh write to addr 0 commits.
6. Back-to-back writes to addr 0 = 0x11 and addr 4 = 0x22 with a minimum cs_n high time of 3 clk -> both commit with two separate wr_strobe pulses. Repeat at f_sclk = f_clk/6 with random phase -> no missed bits.
